rr_arbiter9: RTL and testbench
==============================

// Module: rr_arbiter9
// PURPOSE
//  Round-robin arbiter sharing one 16-bit output bus among 9 requesters.
//  Contains the 9:1 word select and drives the 4-bit select code (0..8 = owner, 15 = idle).
//  Holds a grant for a burst, using a valid/ready handshake toward the consumer.
//  Sits between the 9 word sources and the single downstream sink.
// PARAMETERS
//  BURST   4   max beats per grant before forced rotation (1..15)
//  IDLE_W  16'hFFFF  value driven on out_data when no owner
// PORTS
//  clk        in   1     clock; all state updates on posedge
//  reset      in   1     synchronous, active-high
//  req        in   9     req[i]=1: requester i has a valid word on its data slice
//  last       in   9     last[i]=1: current word of requester i is its final word
//  in_data    in   144   requester i word = in_data[16*i +: 16]
//  out_ready  in   1     sink accepts out_data this cycle
//  out_valid  out  1     comb: granted & req[sel]
//  out_data   out  16    comb: in_data slice of sel when granted, else IDLE_W
//  sel        out  4     registered owner index 0..8; 4'd15 when idle
//  grant      out  9     registered one-hot owner; 0 when idle
//  ack        out  9     comb: ack[i] = out_valid & out_ready & (sel==i)
// BEHAVIOUR
//  Reset: sel=15, grant=0, ptr=0, beat_cnt=0, state=IDLE. Outputs follow: out_valid=0,
//   out_data=IDLE_W, ack=0. Reset mid-burst drops the grant next edge; no ack that cycle
//   unless the comb handshake completes before the edge.
//  State IDLE: if |req, pick the first i with req[i]=1 scanning ptr, ptr+1, ..., wrapping mod 9.
//   Next edge: state=GRANT, sel=i, grant=1<<i, beat_cnt=0. If req==0, stay IDLE.
//  Latency: req rises in cycle N, out_valid=1 in cycle N+1.
//  State GRANT:
//   beat = out_valid & out_ready.
//   beat & (last[sel] | beat_cnt==BURST-1) -> release.
//   beat otherwise -> beat_cnt++, hold grant.
//   !req[sel] (requester withdrew, no beat) -> abort; same as release.
//   No beat & req[sel] -> hold; sel, grant and out_data stay stable (sink back-pressure).
//  Release/abort: next edge state=IDLE, sel=15, grant=0, ptr=(sel==8)?0:sel+1.
//   Gives exactly one bubble cycle between owners. The released requester has lowest
//   priority in the next arbitration.
//  ptr changes only on release/abort. Requesters that never assert are skipped.
//  No starvation: any steadily asserted req is granted within 8 grants.
//  sel never takes values 9..14. grant is always one-hot or zero; checked by assertion.
//  Widths: beat_cnt 4 bits; ptr 4 bits, range 0..8.
// TESTING
//  1. reset, req=9'h001, last[0]=1, ready=1 -> cycle+1 sel=0, out_valid=1, ack[0]=1; next sel=15
//  2. req=9'h1FF, all last=1, ready=1 -> owners 0,1,2..8,0 with one idle cycle between each
//  3. req[3] held, last=0, BURST=4, ready=1 -> 4 acks on sel=3, release; ptr=4; regrant 3 if alone
//  4. owner 5, ready=0 for 6 cycles -> sel=5, out_data=in_data[95:80] stable, ack=0; resumes on ready
//  5. owner 2 drops req with no beat -> next cycle sel=15, grant=0; following grant goes to next req after 2
//  6. reset asserted mid-burst (owner 7) -> next edge sel=15, grant=0, ptr=0; next grant is lowest req

Source files
------------

// File: rtl/rr_arbiter9.sv
// ============================================================================
// Module      : rr_arbiter9
// Description : Round-robin arbiter sharing one 16-bit bus among 9 requesters,
//               holding each grant for a burst under a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter9 #(
    parameter int unsigned BURST  = 4,
    parameter logic [15:0] IDLE_W = 16'hFFFF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [8:0]   req,
    input  logic [8:0]   last,
    input  logic [143:0] in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [15:0]  out_data,
    output logic [3:0]   sel,
    output logic [8:0]   grant,
    output logic [8:0]   ack
);

    localparam int unsigned c_NREQ     = 9;
    localparam logic [0:0]  c_IDLE     = 1'b0;
    localparam logic [0:0]  c_GRANT    = 1'b1;
    localparam logic [3:0]  c_SEL_IDLE = 4'd15;
    localparam logic [3:0]  c_LAST_BT  = 4'(BURST - 1);

    logic [0:0]  r_state;
    logic [3:0]  r_sel;
    logic [8:0]  r_grant;
    logic [3:0]  r_ptr;
    logic [3:0]  r_beat_cnt;

    logic [3:0]  w_scan_idx [c_NREQ];
    logic [15:0] w_masked   [c_NREQ];
    logic        w_pick_valid;
    logic [3:0]  w_pick;
    logic        w_req_sel;
    logic        w_last_sel;
    logic        w_beat;
    logic        w_release;
    logic [15:0] w_word;
    logic [3:0]  w_next_ptr;

    // Candidate order for this arbitration: ptr, ptr+1, ... wrapping mod 9.
    generate
        for (genvar k = 0; k < c_NREQ; k++) begin : g_scan
            logic [4:0] w_sum;
            assign w_sum         = {1'b0, r_ptr} + 5'(k);
            assign w_scan_idx[k] = (w_sum >= 5'd9) ? 4'(w_sum - 5'd9) : w_sum[3:0];
        end
    endgenerate

    // Walk the order backwards so the closest requester to ptr wins last.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick       = 4'd0;
        for (int k = c_NREQ - 1; k >= 0; k--) begin
            if (req[w_scan_idx[k]]) begin
                w_pick_valid = 1'b1;
                w_pick       = w_scan_idx[k];
            end
        end
    end

    generate
        for (genvar i = 0; i < c_NREQ; i++) begin : g_mux
            assign w_masked[i] = in_data[16*i +: 16] & {16{r_grant[i]}};
        end
    endgenerate

    // grant is one-hot, so an AND-OR reduction is the 9:1 select.
    always_comb begin
        w_word = 16'd0;
        for (int i = 0; i < c_NREQ; i++) begin
            w_word = w_word | w_masked[i];
        end
    end

    assign w_req_sel  = |(req & r_grant);
    assign w_last_sel = |(last & r_grant);
    assign w_beat     = out_valid & out_ready;
    assign w_release  = (w_beat & (w_last_sel | (r_beat_cnt == c_LAST_BT))) | ~w_req_sel;
    assign w_next_ptr = (r_sel == 4'd8) ? 4'd0 : r_sel + 4'd1;

    assign out_valid = (r_state == c_GRANT) & w_req_sel;
    assign out_data  = (r_state == c_GRANT) ? w_word : IDLE_W;
    assign ack       = {c_NREQ{w_beat}} & r_grant;
    assign sel       = r_sel;
    assign grant     = r_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_sel      <= c_SEL_IDLE;
            r_grant    <= 9'd0;
            r_ptr      <= 4'd0;
            r_beat_cnt <= 4'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_pick_valid) begin
                        r_state    <= c_GRANT;
                        r_sel      <= w_pick;
                        r_grant    <= 9'd1 << w_pick;
                        r_beat_cnt <= 4'd0;
                    end
                end
                c_GRANT: begin
                    if (w_release) begin
                        r_state    <= c_IDLE;
                        r_sel      <= c_SEL_IDLE;
                        r_grant    <= 9'd0;
                        r_ptr      <= w_next_ptr;
                        r_beat_cnt <= 4'd0;
                    end else if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_sel   <= c_SEL_IDLE;
                    r_grant <= 9'd0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_grant_onehot : assert property (@(posedge clk) disable iff (reset)
        $onehot0(r_grant));
    a_sel_range : assert property (@(posedge clk) disable iff (reset)
        (r_sel <= 4'd8) || (r_sel == c_SEL_IDLE));
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter9.sv
// ============================================================================
// Module      : tb_rr_arbiter9
// Description : Directed self-checking bench for rr_arbiter9.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter9;

    logic         clk;
    logic         reset;
    logic [8:0]   req;
    logic [8:0]   last;
    logic [143:0] in_data;
    logic         out_ready;
    logic         out_valid;
    logic [15:0]  out_data;
    logic [3:0]   sel;
    logic [8:0]   grant;
    logic [8:0]   ack;

    int n_chk  = 0;
    int n_fail = 0;

    rr_arbiter9 #(.BURST(4), .IDLE_W(16'hFFFF)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .last      (last),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .grant     (grant),
        .ack       (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 9'd0;
        last  = 9'd0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // word i = (i+1) << 12: 0x1000 .. 0x9000
        in_data = 144'd0;
        for (int i = 0; i < 9; i++) in_data[16*i +: 16] = 16'((i + 1) << 12);

        // Reset state
        do_reset();
        chk("rst_sel",   sel, 4'd15);
        chk("rst_grant", grant, 9'd0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data",  out_data, 16'hFFFF);
        chk("rst_ack",   ack, 9'd0);

        // 1: single requester, single-word burst
        req = 9'h001; last = 9'h001; out_ready = 1'b1;
        tick();
        chk("t1_sel",   sel, 4'd0);
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_ack",   ack, 9'h001);
        chk("t1_data",  out_data, 16'h1000);
        tick();
        chk("t1_rel_sel",   sel, 4'd15);
        chk("t1_rel_grant", grant, 9'd0);
        req = 9'd0;

        // 2: everyone requesting, one-word bursts -> 0..8,0 with bubbles
        do_reset();
        req = 9'h1FF; last = 9'h1FF; out_ready = 1'b1;
        for (int g = 0; g < 10; g++) begin
            tick();
            chk("t2_sel",   sel, 32'(g % 9));
            chk("t2_ack",   ack, 32'(9'd1 << (g % 9)));
            chk("t2_data",  out_data, 32'(((g % 9) + 1) << 12));
            tick();
            chk("t2_bubble", sel, 4'd15);
        end
        req = 9'd0;
        tick();

        // 3: burst limit on requester 3 (ptr is 1 here)
        req = 9'h008; last = 9'd0; out_ready = 1'b1;
        tick();
        for (int b = 0; b < 4; b++) begin
            chk("t3_sel", sel, 4'd3);
            chk("t3_ack", ack, 9'h008);
            tick();
        end
        chk("t3_rel", sel, 4'd15);
        tick();
        chk("t3_regrant", sel, 4'd3);
        req = 9'd0;
        tick();
        chk("t3_abort", sel, 4'd15);
        req = 9'h00C;
        tick();
        chk("t3_ptr4_pick2", sel, 4'd2);
        req = 9'd0;
        tick();

        // 4: back-pressure on owner 5
        do_reset();
        req = 9'h020; last = 9'h020; out_ready = 1'b0;
        tick();
        for (int c = 0; c < 6; c++) begin
            chk("t4_sel",   sel, 4'd5);
            chk("t4_data",  out_data, 16'h6000);
            chk("t4_ack",   ack, 9'd0);
            chk("t4_valid", out_valid, 1'b1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("t4_resume_ack", ack, 9'h020);
        tick();
        chk("t4_rel", sel, 4'd15);
        req = 9'd0;

        // 5: owner 2 withdraws without a beat
        do_reset();
        req = 9'h034; last = 9'd0; out_ready = 1'b0;
        tick();
        chk("t5_sel", sel, 4'd2);
        req = 9'h030;
        #1;
        chk("t5_valid_drop", out_valid, 1'b0);
        tick();
        chk("t5_abort_sel",   sel, 4'd15);
        chk("t5_abort_grant", grant, 9'd0);
        tick();
        chk("t5_next_sel",   sel, 4'd4);
        chk("t5_next_grant", grant, 9'h010);
        req = 9'd0;

        // 6: reset mid-burst on owner 7
        do_reset();
        req = 9'h080; last = 9'd0; out_ready = 1'b1;
        tick();
        chk("t6_sel", sel, 4'd7);
        tick();
        chk("t6_hold", sel, 4'd7);
        reset = 1'b1;
        req = 9'h0A2;
        tick();
        chk("t6_rst_sel",   sel, 4'd15);
        chk("t6_rst_grant", grant, 9'd0);
        chk("t6_rst_valid", out_valid, 1'b0);
        reset = 1'b0;
        tick();
        chk("t6_lowest", sel, 4'd1);
        chk("t6_lowest_data", out_data, 16'h2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
